cordic_rotate_fsm: RTL
======================

# cordic_rotate_fsm

Iterative rotation-mode CORDIC that converts a phase into a sine/cosine pair. It is the inverse of the vectoring CORDIC FSM, which turns sin/cos into phase: it consumes phases in the same scaling (PI = 2^23−1) with the same arctangent table, and emits 24-bit sin/cos. It is used for phase-to-I/Q regeneration and closed-loop checks against the vectoring block.

## Interface
Parameters:
- BIT_WIDTH_IN, 27: signed phase input width.
- BIT_WIDTH_OUT, 24: signed sin/cos output width.
- N_ITER, 24: number of micro-rotations, equal to the angle_table length.
- PI, 8388607: phase code for +π.
- X_INIT, 5094006: initial x, equal to round(K·(2^(BIT_WIDTH_OUT−1)−1)) with K = 0.6072529.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: synchronous, active-high reset.
- start_i, input, 1: request a computation. Sampled only in IDLE.
- phi_i, input, BIT_WIDTH_IN signed: phase, valid range [−PI, PI].
- angle_table, input, N_ITER×BIT_WIDTH_OUT signed: atan(2^−i) in phase units. Entry 0 is PI/4 = 2097151.
- sin_o, output, BIT_WIDTH_OUT signed: sine result.
- cos_o, output, BIT_WIDTH_OUT signed: cosine result.
- busy_o, output, 1: high while in ROTATE or FINISH.
- done_o, output, 1: one-cycle pulse; sin_o/cos_o are valid from this cycle on.

## Operation
- States: IDLE, ROTATE, FINISH.
- Reset: state IDLE; sin_o = 0, cos_o = 0, done_o = 0, busy_o = 0; iteration counter = 0.
- **IDLE**
  - On an edge with start_i = 1, perform quadrant pre-reduction:
    - phi_i > PI/2 (4194303): z = phi_i − PI, neg = 1.
    - phi_i < −PI/2: z = phi_i + PI, neg = 1.
    - Otherwise z = phi_i, neg = 0.
  - Load x = X_INIT, y = 0, counter = 0, then go to ROTATE.
- **ROTATE**
  - Each edge performs iteration i = counter, with d = +1 if z ≥ 0, else −1:
    - x ← x − d·(y >>> i)
    - y ← y + d·(x >>> i)
    - z ← z − d·angle_table[i]
  - All right-hand sides use the pre-edge values. Shifts are arithmetic.
  - After i = N_ITER−1, go to FINISH.
- **FINISH**
  - If neg = 1, negate x and y.
  - Saturate both to ±(2^(BIT_WIDTH_OUT−1)−1).
  - Register cos_o = x and sin_o = y, set done_o = 1, go to IDLE.
- Widths:
  - x and y are held at BIT_WIDTH_OUT+2 bits (guard against gain overshoot).
  - z is held at BIT_WIDTH_IN bits; angle_table entries are sign-extended to that width.
- start_i is ignored while busy_o = 1. No queueing.
- sin_o/cos_o hold their value until the next FINISH.
- |phi_i| > PI is a caller error: the outputs are unspecified, but done_o still pulses with normal latency.
- ±PI both map to cos = −max, sin ≈ 0.

## Timing
- If start_i is sampled at edge k:
  - busy_o is high from after edge k until after edge k+N_ITER+1.
  - done_o is high for exactly the one cycle following edge k+N_ITER+1 (25 cycles with defaults).
- The earliest next start is sampled at edge k+N_ITER+2, i.e. while done_o is high. Back-to-back period is N_ITER+2 cycles.
- If reset_i coincides with start_i, or arrives at any point mid-ROTATE/FINISH, reset wins: state IDLE and all outputs 0 on the next cycle, and no done_o pulse.
- phi_i and angle_table are sampled only at the start edge. angle_table must remain stable through ROTATE.

## Structure
- Shared package cordic_pkg holds:
  - the state enum;
  - PI and PI/2 localparams;
  - the X_INIT constant;
  - the default 24-entry arctangent table constant, shared with the vectoring FSM and its wrapper.
- Sub-module cordic_micro_rotation: combinational single iteration.
  - Inputs: x, y, z, i, table entry.
  - Outputs: x', y', z'.
  - Reusable by the vectoring block. The counter and saturation stay in the top level.

## Test plan
All expected sin/cos values are to within ±32 LSB.
- phi_i = 0 → cos_o ≈ 8388607, sin_o ≈ 0; done_o exactly 25 cycles after start.
- phi_i = 2097151 (π/4) → sin_o ≈ cos_o ≈ 5931641.
- phi_i = 4194303 (π/2) → sin_o ≈ 8388607, cos_o ≈ 0. phi_i = −6291455 (−3π/4) → sin_o ≈ cos_o ≈ −5931641. Both results saturate-safe (no wrap to positive).
- phi_i = ±8388607 → cos_o ≈ −8388607, sin_o ≈ 0.
- Busy and back-to-back behaviour:
  - start_i is held high continuously → results every 26 cycles; busy_o has no gaps except one cycle.
  - A pulse on start_i mid-ROTATE is ignored.
- reset_i asserted at iteration 10 → next cycle state IDLE, sin_o = cos_o = 0, done_o never pulses. A fresh start afterwards gives correct results.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the rotation and vectoring CORDIC blocks:
// controller states, phase scaling constants and the arctangent table.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        FINISH = 2'd2
    } cordic_state_e;

    localparam int CORDIC_N_ITER  = 24;
    localparam int CORDIC_W_IN    = 27;
    localparam int CORDIC_W_OUT   = 24;

    // Phase code for +pi; the full circle spans [-PI, PI].
    localparam int CORDIC_PI      = 8388607;
    localparam int CORDIC_PI_HALF = CORDIC_PI / 2;

    // Starting x pre-scaled by the CORDIC gain compensation K = 0.6072529.
    localparam int CORDIC_X_INIT  = 5094006;

    // atan(2^-i) in phase units, rounded; listed from entry 23 down to entry 0.
    localparam logic [CORDIC_N_ITER-1:0][CORDIC_W_OUT-1:0] CORDIC_ATAN_TABLE = {
        24'd0,      24'd1,      24'd1,      24'd3,
        24'd5,      24'd10,     24'd20,     24'd41,
        24'd81,     24'd163,    24'd326,    24'd652,
        24'd1304,   24'd2608,   24'd5215,   24'd10430,
        24'd20860,  24'd41718,  24'd83416,  24'd166669,
        24'd332050, 24'd654136, 24'd1238021, 24'd2097151
    };

endpackage

// File: rtl/cordic_micro_rotation.sv
// One CORDIC micro-rotation: rotates (x, y) by +/-atan(2^-i) in the direction
// that drives z toward zero. Purely combinational so the rotation and
// vectoring controllers can both wrap it with their own counters.
module cordic_micro_rotation #(
    parameter int XW = 26,
    parameter int ZW = 27,
    parameter int AW = 24,
    parameter int IW = 5
) (
    input  logic signed [XW-1:0] i_x,
    input  logic signed [XW-1:0] i_y,
    input  logic signed [ZW-1:0] i_z,
    input  logic        [IW-1:0] i_iter,
    input  logic signed [AW-1:0] i_angle,
    output logic signed [XW-1:0] o_x,
    output logic signed [XW-1:0] o_y,
    output logic signed [ZW-1:0] o_z
);

    logic signed [XW-1:0] w_x_shift;
    logic signed [XW-1:0] w_y_shift;
    logic signed [ZW-1:0] w_angle_ext;

    assign w_x_shift   = i_x >>> i_iter;
    assign w_y_shift   = i_y >>> i_iter;
    assign w_angle_ext = {{(ZW-AW){i_angle[AW-1]}}, i_angle};

    // Rotate counter-clockwise while the residual angle is non-negative, clockwise otherwise.
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        o_z = i_z;
        if (!i_z[ZW-1]) begin
            o_x = i_x - w_y_shift;
            o_y = i_y + w_x_shift;
            o_z = i_z - w_angle_ext;
        end else begin
            o_x = i_x + w_y_shift;
            o_y = i_y - w_x_shift;
            o_z = i_z + w_angle_ext;
        end
    end

endmodule

// File: rtl/cordic_rotate_fsm.sv
// Iterative rotation-mode CORDIC: turns a phase code into a saturated
// sine/cosine pair, one micro-rotation per clock, N_ITER+2 cycles per result.
module cordic_rotate_fsm
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH_IN  = 27,
    parameter int BIT_WIDTH_OUT = 24,
    parameter int N_ITER        = 24,
    parameter int PI            = 8388607,
    parameter int X_INIT        = 5094006
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 start_i,
    input  logic signed [BIT_WIDTH_IN-1:0]       phi_i,
    input  logic [N_ITER-1:0][BIT_WIDTH_OUT-1:0] angle_table,
    output logic signed [BIT_WIDTH_OUT-1:0]      sin_o,
    output logic signed [BIT_WIDTH_OUT-1:0]      cos_o,
    output logic                                 busy_o,
    output logic                                 done_o
);

    // x/y carry two guard bits so the gain overshoot near full scale cannot wrap.
    localparam int XW = BIT_WIDTH_OUT + 2;
    localparam int ZW = BIT_WIDTH_IN;
    localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    localparam logic [CW-1:0]        LAST_ITER   = CW'(N_ITER - 1);
    localparam logic signed [ZW-1:0] PI_Z        = ZW'(PI);
    localparam logic signed [ZW-1:0] PI_HALF_Z   = ZW'(PI / 2);
    localparam logic signed [ZW-1:0] M_PI_HALF_Z = ZW'(-(PI / 2));
    localparam logic signed [XW-1:0] X_INIT_X    = XW'(X_INIT);
    localparam logic signed [XW-1:0] SAT_MAX     = XW'((2 ** (BIT_WIDTH_OUT - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_MIN     = XW'(-((2 ** (BIT_WIDTH_OUT - 1)) - 1));

    cordic_state_e r_state;
    cordic_state_e w_next_state;

    logic signed [XW-1:0]            r_x;
    logic signed [XW-1:0]            r_y;
    logic signed [ZW-1:0]            r_z;
    logic                            r_neg;
    logic [CW-1:0]                   r_cnt;
    logic signed [BIT_WIDTH_OUT-1:0] r_sin;
    logic signed [BIT_WIDTH_OUT-1:0] r_cos;
    logic                            r_done;

    logic signed [XW-1:0]            w_x_rot;
    logic signed [XW-1:0]            w_y_rot;
    logic signed [ZW-1:0]            w_z_rot;
    logic signed [ZW-1:0]            w_z_pre;
    logic                            w_neg_pre;
    logic signed [XW-1:0]            w_x_fin;
    logic signed [XW-1:0]            w_y_fin;
    logic signed [BIT_WIDTH_OUT-1:0] w_cos_sat;
    logic signed [BIT_WIDTH_OUT-1:0] w_sin_sat;
    logic signed [BIT_WIDTH_OUT-1:0] w_angle;
    logic                            w_busy;

    // Clamp a guard-bit value symmetrically into the output range.
    function automatic logic signed [BIT_WIDTH_OUT-1:0] saturate(input logic signed [XW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[BIT_WIDTH_OUT-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[BIT_WIDTH_OUT-1:0];
        end else begin
            return v[BIT_WIDTH_OUT-1:0];
        end
    endfunction

    assign w_angle = angle_table[r_cnt];

    cordic_micro_rotation #(
        .XW (XW),
        .ZW (ZW),
        .AW (BIT_WIDTH_OUT),
        .IW (CW)
    ) u_micro (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_iter  (r_cnt),
        .i_angle (w_angle),
        .o_x     (w_x_rot),
        .o_y     (w_y_rot),
        .o_z     (w_z_rot)
    );

    // Fold phases outside [-pi/2, pi/2] by pi; the result is negated at the end.
    always_comb begin
        w_z_pre   = phi_i;
        w_neg_pre = 1'b0;
        if (phi_i > PI_HALF_Z) begin
            w_z_pre   = phi_i - PI_Z;
            w_neg_pre = 1'b1;
        end else if (phi_i < M_PI_HALF_Z) begin
            w_z_pre   = phi_i + PI_Z;
            w_neg_pre = 1'b1;
        end
    end

    // Undo the quadrant fold, then clamp to the symmetric output range.
    always_comb begin
        w_x_fin = r_x;
        w_y_fin = r_y;
        if (r_neg) begin
            w_x_fin = -r_x;
            w_y_fin = -r_y;
        end
        w_cos_sat = saturate(w_x_fin);
        w_sin_sat = saturate(w_y_fin);
    end

    // Controller state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and busy decode; start is only looked at while idle.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next_state = ROTATE;
                end
            end
            ROTATE: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_ITER) begin
                    w_next_state = FINISH;
                end
            end
            FINISH: begin
                w_busy       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: load on start, one micro-rotation per ROTATE cycle, publish in FINISH.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_neg  <= 1'b0;
            r_cnt  <= '0;
            r_sin  <= '0;
            r_cos  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_x   <= X_INIT_X;
                        r_y   <= '0;
                        r_z   <= w_z_pre;
                        r_neg <= w_neg_pre;
                        r_cnt <= '0;
                    end
                end
                ROTATE: begin
                    r_x   <= w_x_rot;
                    r_y   <= w_y_rot;
                    r_z   <= w_z_rot;
                    r_cnt <= (r_cnt == LAST_ITER) ? '0 : r_cnt + 1'b1;
                end
                FINISH: begin
                    r_cos  <= w_cos_sat;
                    r_sin  <= w_sin_sat;
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign sin_o  = r_sin;
    assign cos_o  = r_cos;
    assign done_o = r_done;
    assign busy_o = w_busy;

endmodule
